// File: rtl/axo_mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one shared memory bus.
// Data requests take priority unless the fetch port has been starved for STARVE_LIMIT grants.
module axo_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_re,
    input  logic [31:1] prog_addr,
    output logic        prog_ready,
    output logic [31:0] prog_data,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [1:0]  mem_asize,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        bus_re,
    output logic        bus_we,
    output logic [1:0]  bus_asize,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] streak;
    logic [WW-1:0] wait_cnt;
    logic          data_req, busy;
    logic          grant_fetch, grant_data, done, abort;

    assign data_req = mem_re | mem_we;
    assign busy     = (state == FETCH) || (state == DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        done        = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                // A starved fetch wins only when both ports are asking.
                if (data_req && !(prog_re && streak == STREAK_MAX)) begin
                    grant_data = 1'b1;
                    state_nx   = DATA;
                end else if (prog_re) begin
                    grant_fetch = 1'b1;
                    state_nx    = FETCH;
                end
            end
            FETCH, DATA: begin
                if (bus_ready) begin
                    done     = 1'b1;
                    state_nx = RESP;
                end else if (wait_cnt == WAIT_MAX) begin
                    abort    = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak     <= '0;
            wait_cnt   <= '0;
            bus_re     <= 1'b0;
            bus_we     <= 1'b0;
            bus_asize  <= 2'd0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_err    <= 1'b0;
            prog_ready <= 1'b0;
            prog_data  <= 32'd0;
            mem_ready  <= 1'b0;
            mem_rdata  <= 32'd0;
        end else begin
            prog_ready <= 1'b0;
            mem_ready  <= 1'b0;
            bus_err    <= 1'b0;
            if (grant_fetch) begin
                bus_re    <= 1'b1;
                bus_we    <= 1'b0;
                bus_asize <= 2'd2;
                bus_addr  <= {prog_addr, 1'b0};
                bus_wdata <= 32'd0;
                streak    <= '0;
                wait_cnt  <= '0;
            end
            if (grant_data) begin
                bus_re    <= ~mem_we;
                bus_we    <= mem_we;
                bus_asize <= mem_asize;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                wait_cnt  <= '0;
                if (streak != STREAK_MAX) streak <= streak + 1'b1;
            end
            if (done || abort) begin
                bus_re  <= 1'b0;
                bus_we  <= 1'b0;
                bus_err <= abort;
                // An aborted transfer still completes toward its requester, with zero data.
                if (state == FETCH) begin
                    prog_ready <= 1'b1;
                    prog_data  <= abort ? 32'd0 : bus_rdata;
                end else begin
                    mem_ready <= 1'b1;
                    mem_rdata <= abort ? 32'd0 : bus_rdata;
                end
            end else if (busy) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule
